spi_bus_loader: RTL and testbench

//  SPI-slave to internal-bus bridge for embed-mode program load and debug. External host drives
//  SCK/MOSI; the block runs in the system clock domain, builds read/write bus transactions and

---
 rtl/spi_bus_loader.sv | 255 +++++++++++++++++++++++++
 tb/tb_spi_bus_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_loader.sv
// SPI-slave to internal-bus bridge: the host shifts in address/command/data frames on SCK/MOSI,
// the block issues bus transactions and returns done, status and read data on MISO.
module spi_bus_loader #(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 16,
    parameter int BURST_EN = 1,
    parameter int TIMEOUT  = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_spi_clk,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_data,
    input  logic [DATA_W-1:0] i_bus_data,
    input  logic              i_bus_ack,
    input  logic              i_bus_err,
    output logic              o_frame_err
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_CMD, S_WDATA, S_BUS, S_DONE, S_STAT, S_RDATA, S_CONT
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sck_sync_q, mosi_sync_q;
    logic               sck_prev_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               we_q, we_d;
    logic               inc_q, inc_d;
    logic               err_q, err_d;
    logic               req_q, req_d;
    logic               miso_q, miso_d;
    logic               abort_q, abort_d;
    logic               frame_err_q, frame_err_d;

    logic sck_s, mosi_s, sck_rise, sck_fall, timeout, abortable;

    assign sck_s     = sck_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign sck_rise  = sck_s & ~sck_prev_q;
    assign sck_fall  = ~sck_s & sck_prev_q;
    assign timeout   = (tmo_q == TMO_W'(TIMEOUT));
    assign abortable = (state_q != S_IDLE) && (state_q != S_BUS);

    // Synchronisers idle high to match the SCK/MOSI bus idle level
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            sck_sync_q  <= 2'b11;
            mosi_sync_q <= 2'b11;
            sck_prev_q  <= 1'b1;
            cnt_q       <= '0;
            tmo_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            rdata_q     <= '0;
            we_q        <= 1'b0;
            inc_q       <= 1'b0;
            err_q       <= 1'b0;
            req_q       <= 1'b0;
            miso_q      <= 1'b1;
            abort_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= {sck_sync_q[0], i_spi_clk};
            mosi_sync_q <= {mosi_sync_q[0], i_spi_mosi};
            sck_prev_q  <= sck_s;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rdata_q     <= rdata_d;
            we_q        <= we_d;
            inc_q       <= inc_d;
            err_q       <= err_d;
            req_q       <= req_d;
            miso_q      <= miso_d;
            abort_q     <= abort_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rdata_d     = rdata_q;
        we_d        = we_q;
        inc_d       = inc_q;
        err_d       = err_q;
        req_d       = req_q;
        miso_d      = miso_q;
        abort_d     = abort_q;
        frame_err_d = 1'b0;

        if (!abortable || sck_rise || sck_fall) begin
            tmo_d = '0;
        end else if (!timeout) begin
            tmo_d = tmo_q + TMO_W'(1);
        end else begin
            tmo_d = tmo_q;
        end

        // Disable drops the frame silently; a stalled host is flagged with o_frame_err
        if (abortable && (!i_en || timeout)) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            tmo_d       = '0;
            miso_d      = 1'b1;
            frame_err_d = i_en;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sck_fall) begin
                        miso_d = 1'b1;
                    end
                    if (i_en && sck_rise && !mosi_s) begin
                        state_d = S_ADDR;
                        cnt_d   = '0;
                    end
                end
                S_ADDR: begin
                    if (sck_rise) begin
                        addr_d = {mosi_s, addr_q[ADDR_W-1:1]};
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                            state_d = S_CMD;
                            cnt_d   = '0;
                        end
                    end
                end
                S_CMD: begin
                    if (sck_rise) begin
                        if (cnt_q == '0) begin
                            we_d  = mosi_s;
                            inc_d = 1'b0;
                        end else begin
                            inc_d = mosi_s;
                        end
                        if (cnt_q == '0 && BURST_EN != 0) begin
                            cnt_d = CNT_W'(1);
                        end else begin
                            cnt_d = '0;
                            if (we_d) begin
                                state_d = S_WDATA;
                            end else begin
                                state_d = S_BUS;
                                req_d   = 1'b1;
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (sck_rise) begin
                        data_d = {mosi_s, data_q[DATA_W-1:1]};
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_d = S_BUS;
                            req_d   = 1'b1;
                            cnt_d   = '0;
                        end
                    end
                end
                S_BUS: begin
                    if (!i_en) begin
                        abort_d = 1'b1;
                    end
                    if (i_bus_ack || i_bus_err) begin
                        req_d   = 1'b0;
                        err_d   = i_bus_err;
                        rdata_d = i_bus_err ? '0 : i_bus_data;
                        if (abort_q || !i_en) begin
                            state_d = S_IDLE;
                            abort_d = 1'b0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (sck_fall) begin
                        miso_d  = 1'b0;
                        state_d = S_STAT;
                    end
                end
                S_STAT: begin
                    if (sck_fall) begin
                        miso_d = err_q;
                        cnt_d  = '0;
                        if (!we_q) begin
                            state_d = S_RDATA;
                        end else begin
                            state_d = inc_q ? S_CONT : S_IDLE;
                        end
                    end
                end
                S_RDATA: begin
                    if (sck_fall) begin
                        miso_d  = rdata_q[0];
                        rdata_d = {1'b0, rdata_q[DATA_W-1:1]};
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            cnt_d   = '0;
                            state_d = inc_q ? S_CONT : S_IDLE;
                        end
                    end
                end
                S_CONT: begin
                    // The continuation bit is only accepted after MISO has returned high
                    if (sck_fall) begin
                        miso_d = 1'b1;
                        cnt_d  = CNT_W'(1);
                    end else if (sck_rise && cnt_q != '0) begin
                        cnt_d = '0;
                        if (mosi_s) begin
                            state_d = S_IDLE;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                            if (we_q) begin
                                state_d = S_WDATA;
                            end else begin
                                state_d = S_BUS;
                                req_d   = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign o_spi_miso  = miso_q;
    assign o_bus_req   = req_q;
    assign o_bus_we    = we_q;
    assign o_bus_addr  = addr_q;
    assign o_bus_data  = data_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_bus_loader.sv
// Testbench for spi_bus_loader: a host model clocks frames over SPI, a bus responder answers
// requests, and a bus monitor scores each request against the queue of expected transactions.
module tb_spi_bus_loader;

    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 4096;
    localparam int PH      = 5;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, sck = 1'b1, mosi = 1'b1;
    logic ack = 1'b0, err = 1'b0;
    logic [DATA_W-1:0] rdat = '0;
    logic miso, req, we, fe;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdat;

    always #5 clk = ~clk;

    spi_bus_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_EN(1), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_spi_clk(sck), .i_spi_mosi(mosi),
        .o_spi_miso(miso), .o_bus_req(req), .o_bus_we(we), .o_bus_addr(addr),
        .o_bus_data(wdat), .i_bus_data(rdat), .i_bus_ack(ack), .i_bus_err(err),
        .o_frame_err(fe)
    );

    typedef struct { logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } busExp_t;
    typedef struct { int delay; logic ack; logic err; logic [DATA_W-1:0] data; } resp_t;

    busExp_t expQ[$];
    resp_t   respQ[$];
    int checks = 0, errors = 0, feCount = 0;

    logic [DATA_W-1:0] wdataArr[8];
    logic [DATA_W-1:0] respData[8];
    int                respDelay[8];
    logic              respAck[8], respErr[8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One SCK period: fall with new MOSI, rise, then sample MISO just before the next fall
    task automatic applyStimulus(input logic b, output logic m);
        @(negedge clk);
        sck  = 1'b0;
        mosi = b;
        repeat (PH) @(negedge clk);
        sck = 1'b1;
        repeat (PH) @(negedge clk);
        m = miso;
    endtask

    task automatic sendHeader(input logic w, input logic [ADDR_W-1:0] a, input logic inc);
        logic m;
        applyStimulus(1'b0, m);
        for (int i = 0; i < ADDR_W; i++) applyStimulus(a[i], m);
        applyStimulus(w, m);
        applyStimulus(inc, m);
    endtask

    task automatic sendData(input logic [DATA_W-1:0] d);
        logic m;
        for (int i = 0; i < DATA_W; i++) applyStimulus(d[i], m);
    endtask

    task automatic queueWord(input logic w, input logic [ADDR_W-1:0] a, input int k);
        busExp_t e;
        resp_t r;
        e.we = w; e.addr = a; e.data = wdataArr[k];
        r.delay = respDelay[k]; r.ack = respAck[k]; r.err = respErr[k]; r.data = respData[k];
        expQ.push_back(e);
        respQ.push_back(r);
    endtask

    task automatic setResp(input int k, input int d, input logic a, input logic e, input logic [DATA_W-1:0] v);
        respDelay[k] = d; respAck[k] = a; respErr[k] = e; respData[k] = v;
    endtask

    // Busy bits, then DONE=0, STAT, and for reads the data word (zero on error)
    task automatic readBack(input logic w, input int k);
        logic m;
        logic [DATA_W-1:0] rd;
        int n;
        m = 1'b1;
        n = 0;
        rd = '0;
        while (m === 1'b1 && n < 100) begin
            applyStimulus(1'b1, m);
            n++;
        end
        checkOutput("done_bit", m, 0);
        applyStimulus(1'b1, m);
        checkOutput("stat_bit", m, respErr[k]);
        if (!w) begin
            for (int i = 0; i < DATA_W; i++) begin
                applyStimulus(1'b1, m);
                rd[i] = m;
            end
            checkOutput("read_data", rd, respErr[k] ? 32'h0 : 32'(respData[k]));
        end
    endtask

    task automatic runFrame(input logic w, input logic [ADDR_W-1:0] a0, input int n);
        logic [ADDR_W-1:0] a;
        logic m, inc;
        a = a0;
        inc = (n > 1);
        queueWord(w, a, 0);
        sendHeader(w, a, inc);
        if (w) sendData(wdataArr[0]);
        readBack(w, 0);
        for (int k = 1; k < n; k++) begin
            a = a + 1'b1;
            queueWord(w, a, k);
            applyStimulus(1'b0, m);
            checkOutput("cont_miso", m, 1);
            if (w) sendData(wdataArr[k]);
            readBack(w, k);
        end
        if (inc) begin
            applyStimulus(1'b1, m);
            checkOutput("cont_end_miso", m, 1);
        end
    endtask

    task automatic waitReq();
        for (int i = 0; i < 300 && req !== 1'b1; i++) @(negedge clk);
        checkOutput("req_seen", req, 1);
    endtask

    // Bus responder: answers each new request from the response queue after its delay
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (rst_n && req === 1'b1 && !ack && !err) begin
                if (respQ.size() == 0) begin
                    checkOutput("resp_available", 0, 1);
                    r.delay = 0; r.ack = 1'b1; r.err = 1'b0; r.data = '0;
                end else begin
                    r = respQ.pop_front();
                end
                for (int i = 0; i < r.delay && rst_n; i++) @(negedge clk);
                if (rst_n) begin
                    #1;
                    ack = r.ack; err = r.err; rdat = r.data;
                    @(negedge clk);
                    #1;
                    ack = 1'b0; err = 1'b0; rdat = DATA_W'($urandom);
                end
            end
        end
    end

    // Bus monitor: scores new requests, request stability, request release and o_frame_err pulses
    logic reqPrev = 1'b0, fePrev = 1'b0;
    busExp_t cur;
    always @(negedge clk) begin
        if (rst_n) begin
            if (req === 1'b1 && !reqPrev) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_req", 1, 0);
                end else begin
                    cur = expQ.pop_front();
                    checkOutput("bus_we", we, cur.we);
                    checkOutput("bus_addr", addr, cur.addr);
                    if (cur.we) checkOutput("bus_wdata", wdat, cur.data);
                end
            end else if (req === 1'b1 && reqPrev) begin
                checkOutput("bus_stable", {we, addr}, {cur.we, cur.addr});
            end
            if (reqPrev && (ack || err)) checkOutput("req_drop", req, 0);
            else if (reqPrev) checkOutput("req_held", req, 1);
            if (fe === 1'b1) begin
                feCount++;
                checkOutput("frame_err_width", fePrev, 0);
            end
        end
        reqPrev = (req === 1'b1);
        fePrev  = (fe === 1'b1);
    end

    initial begin
        #950000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic m;
        logic [ADDR_W-1:0] ra;
        logic rw;
        int rn, feBefore;

        repeat (3) @(negedge clk);
        checkOutput("rst_miso", miso, 1);
        checkOutput("rst_req", req, 0);
        checkOutput("rst_we", we, 0);
        checkOutput("rst_addr", addr, 0);
        checkOutput("rst_data", wdat, 0);
        checkOutput("rst_frame_err", fe, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] single write");
        wdataArr[0] = 16'h3888; setResp(0, 3, 1'b1, 1'b0, 16'h0);
        runFrame(1'b1, 24'h800010, 1);

        $display("[TB] single read");
        setResp(0, 1, 1'b1, 1'b0, 16'hBEEF);
        runFrame(1'b0, 24'h000005, 1);

        $display("[TB] burst write across address wrap");
        wdataArr[0] = 16'h1111; wdataArr[1] = 16'h2222; wdataArr[2] = 16'h3333;
        for (int k = 0; k < 3; k++) setResp(k, 2, 1'b1, 1'b0, 16'h0);
        runFrame(1'b1, 24'hFFFFFE, 3);

        $display("[TB] ack and err together, then err-only read");
        wdataArr[0] = 16'h5A5A; setResp(0, 0, 1'b1, 1'b1, 16'h0);
        runFrame(1'b1, 24'h123456, 1);
        setResp(0, 2, 1'b0, 1'b1, 16'hA5A5);
        runFrame(1'b0, 24'h00ABCD, 1);

        $display("[TB] frame timeout");
        feBefore = feCount;
        ra = 24'h2AA555;
        applyStimulus(1'b0, m);
        for (int i = 0; i < 10; i++) applyStimulus(ra[i], m);
        repeat (TIMEOUT + 20) @(negedge clk);
        checkOutput("timeout_pulses", feCount - feBefore, 1);
        checkOutput("timeout_miso", miso, 1);
        wdataArr[0] = 16'hC0DE; setResp(0, 1, 1'b1, 1'b0, 16'h0);
        runFrame(1'b1, 24'h000100, 1);

        $display("[TB] enable dropped during bus phase");
        wdataArr[0] = 16'h7777; setResp(0, 8, 1'b1, 1'b0, 16'h0);
        queueWord(1'b1, 24'h000200, 0);
        sendHeader(1'b1, 24'h000200, 1'b0);
        sendData(wdataArr[0]);
        waitReq();
        en = 1'b0;
        rw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, m);
            rw = rw & m;
        end
        checkOutput("en_low_no_done", rw, 1);
        en = 1'b1;

        $display("[TB] reset during bus phase");
        wdataArr[0] = 16'h3888; setResp(0, 40, 1'b1, 1'b0, 16'h0);
        queueWord(1'b1, 24'h800010, 0);
        sendHeader(1'b1, 24'h800010, 1'b0);
        sendData(wdataArr[0]);
        waitReq();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_req", req, 0);
        checkOutput("async_rst_miso", miso, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        setResp(0, 3, 1'b1, 1'b0, 16'h0);
        runFrame(1'b1, 24'h800010, 1);

        $display("[TB] randomized frames");
        for (int t = 0; t < 25; t++) begin
            rw = 1'($urandom_range(0, 1));
            rn = int'($urandom_range(1, 3));
            ra = ($urandom_range(0, 3) == 0) ? (24'hFFFFFF - ADDR_W'($urandom_range(0, 1)))
                                             : ADDR_W'($urandom);
            for (int k = 0; k < rn; k++) begin
                wdataArr[k] = DATA_W'($urandom);
                if ($urandom_range(0, 3) == 0)
                    setResp(k, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1'b1, DATA_W'($urandom));
                else
                    setResp(k, int'($urandom_range(0, 6)), 1'b1, 1'b0, DATA_W'($urandom));
            end
            runFrame(rw, ra, rn);
        end

        repeat (10) @(negedge clk);
        checkOutput("exp_queue_empty", expQ.size(), 0);
        checkOutput("resp_queue_empty", respQ.size(), 0);
        checkOutput("frame_err_total", feCount, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
